// File: rtl/til305_scan_sched_if.sv
// Update handshake and glyph ROM port of the TIL305 row-scan scheduler.
// The scheduler takes the slave view: it accepts display content and
// issues ROM reads. The environment (upstream + ROM) takes the master view.
interface til305_scan_sched_if;
    logic       upd_valid;
    logic       upd_ready;
    logic [3:0] upd_tens;
    logic [3:0] upd_units;
    logic [2:0] upd_scr_t;
    logic [2:0] upd_scr_u;
    logic       rom_rd;
    logic [5:0] rom_addr;
    logic [6:0] rom_data;

    modport slave (
        input  upd_valid,
        input  upd_tens,
        input  upd_units,
        input  upd_scr_t,
        input  upd_scr_u,
        input  rom_data,
        output upd_ready,
        output rom_rd,
        output rom_addr
    );

    modport master (
        output upd_valid,
        output upd_tens,
        output upd_units,
        output upd_scr_t,
        output upd_scr_u,
        output rom_data,
        input  upd_ready,
        input  rom_rd,
        input  rom_addr
    );
endinterface

// File: rtl/til305_scan_sched.sv
// Row-scan scheduler for the TIL305 two-digit 5x7 matrix.
// Each row slot starts with a blanked window in which the single-port glyph
// ROM is read twice (tens digit, then units digit); the two halves are merged
// into one column pattern that is shown, PWM-gated by BRIGHT, for the rest of
// the slot. New content is parked in a one-deep pending slot and only moves
// to the active content at the start of row 0, so a frame is never mixed.
// All outputs are registered and computed from the next scan position, so
// they line up with the state/counter registers cycle for cycle.
module til305_scan_sched #(
    parameter int ROW_TICKS   = 8192,
    parameter int BLANK_TICKS = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [3:0]         BRIGHT,
    til305_scan_sched_if.slave bus,
    output logic               frame_start,
    output logic [4:0]         ANODE,
    output logic [6:0]         CATHODE
);
    // Counter is at least 4 bits wide because the PWM compare uses count[3:0].
    localparam int CW = ($clog2(ROW_TICKS) < 4) ? 4 : $clog2(ROW_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(ROW_TICKS - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic [2:0] scr_t;
        logic [2:0] scr_u;
    } content_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    row_q, row_d;
    logic [4:0]    anode_q, anode_d;
    logic [6:0]    cathode_q, cathode_d;
    logic          rom_rd_q, rom_rd_d;
    logic [5:0]    rom_addr_q, rom_addr_d;
    logic          frame_q, frame_d;
    logic [6:0]    pat_q, pat_d;
    content_t      act_q, act_d;
    content_t      pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    content_t      offer;
    logic          accept;

    function automatic logic [3:0] sat_glyph(input logic [3:0] g);
        return (g > 4'd9) ? 4'd9 : g;
    endfunction

    function automatic logic [2:0] sat_scroll(input logic [2:0] s);
        return (s > 3'd5) ? 3'd5 : s;
    endfunction

    // Largest address is 9*6+5+4 = 63, so 6-bit arithmetic never wraps.
    function automatic logic [5:0] glyph_addr(input logic [3:0] g,
                                              input logic [2:0] s,
                                              input logic [2:0] r);
        return 6'(g) * 6'd6 + 6'(s) + 6'(r);
    endfunction

    assign offer = '{tens:  sat_glyph(bus.upd_tens),
                     units: sat_glyph(bus.upd_units),
                     scr_t: sat_scroll(bus.upd_scr_t),
                     scr_u: sat_scroll(bus.upd_scr_u)};

    assign accept = bus.upd_valid & ~pend_full_q;

    // Scan position: IDLE until enabled, then BLANK/SHOW per slot, rows 0..4.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        if (!EN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            row_d   = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            row_d   = '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                row_d = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            state_d = (cnt_d < CNT_SHOW) ? ST_BLANK : ST_SHOW;
        end
    end

    // The next cycle is the start of row 0: frame pulse and commit point.
    assign frame_d = (state_d == ST_BLANK) && (cnt_d == '0) && (row_d == 3'd0);

    // Pending/active content: commit pending first, then take a new offer.
    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_d && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = offer;
            pend_full_d = 1'b1;
        end
    end

    // Column pattern: upper three columns from the tens glyph, lower four from units.
    always_comb begin
        pat_d = pat_q;
        if (state_q == ST_BLANK) begin
            if (cnt_q == CW'(1)) begin
                pat_d = bus.rom_data & 7'h70;
            end else if (cnt_q == CW'(2)) begin
                pat_d = pat_q | (bus.rom_data & 7'h0F);
            end
        end
    end

    // Drive values for the next cycle: blank + ROM fetches, or PWM-gated show.
    always_comb begin
        anode_d    = 5'd0;
        cathode_d  = 7'h7F;
        rom_rd_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        case (state_d)
            ST_BLANK: begin
                if (cnt_d == '0) begin
                    rom_rd_d   = 1'b1;
                    rom_addr_d = glyph_addr(act_d.tens, act_d.scr_t, row_d);
                end else if (cnt_d == CW'(1)) begin
                    rom_rd_d   = 1'b1;
                    rom_addr_d = glyph_addr(act_d.units, act_d.scr_u, row_d);
                end
            end
            ST_SHOW: begin
                cathode_d = ~pat_q;
                if (cnt_d[3:0] <= BRIGHT) begin
                    anode_d = 5'd1 << row_d;
                end
            end
            default: begin
                anode_d   = 5'd0;
                cathode_d = 7'h7F;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            anode_q     <= 5'd0;
            cathode_q   <= 7'h7F;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= 6'd0;
            frame_q     <= 1'b0;
            pat_q       <= 7'd0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            frame_q     <= frame_d;
            pat_q       <= pat_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign ANODE         = anode_q;
    assign CATHODE       = cathode_q;
    assign frame_start   = frame_q;
    assign bus.rom_rd    = rom_rd_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.upd_ready = ~pend_full_q;
endmodule

// File: tb/tb_til305_scan_sched.sv
// Randomized bench for til305_scan_sched against a frame-position model.
// The model tracks a single cycle index k within the 5-row frame and derives
// row, slot count, expected drives and ROM addresses from it arithmetically.
module tb_til305_scan_sched;
    localparam int ROW_TICKS   = 32;
    localparam int BLANK_TICKS = 8;
    localparam int FRAME       = 5 * ROW_TICKS;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] BRIGHT;
    logic       frame_start;
    logic [4:0] ANODE;
    logic [6:0] CATHODE;
    logic [6:0] rom_q = 7'd0;
    logic [6:0] rom_mem [64];

    til305_scan_sched_if bus();

    til305_scan_sched #(
        .ROW_TICKS  (ROW_TICKS),
        .BLANK_TICKS(BLANK_TICKS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .BRIGHT     (BRIGHT),
        .bus        (bus),
        .frame_start(frame_start),
        .ANODE      (ANODE),
        .CATHODE    (CATHODE)
    );

    // 100 MHz-style free-running clock.
    always #5 CLK = ~CLK;

    // Synchronous glyph ROM: data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (bus.rom_rd) rom_q <= rom_mem[bus.rom_addr];
    end
    assign bus.rom_data = rom_q;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_bright = 15;

    // Reference model state.
    bit m_run;
    int m_k;
    bit m_pend;
    int m_pt, m_pu, m_pst, m_psu;
    int m_at, m_au, m_ast, m_asu;
    int m_addr;
    int m_bright;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    endtask

    function automatic int sat(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic modelStep(input bit rst, input bit en, input int bright, input bit valid,
                             input int t, input int u, input int st, input int su);
        bit acc;
        if (rst) begin
            m_run = 0; m_k = 0; m_pend = 0; m_addr = 0;
            m_pt = 0; m_pu = 0; m_pst = 0; m_psu = 0;
            m_at = 0; m_au = 0; m_ast = 0; m_asu = 0;
        end else begin
            acc = valid && !m_pend;
            if (!en) begin
                m_run = 0;
            end else begin
                if (!m_run) begin
                    m_run = 1;
                    m_k = 0;
                end else begin
                    m_k = (m_k + 1) % FRAME;
                end
                if (m_k == 0 && m_pend) begin
                    m_at = m_pt; m_au = m_pu; m_ast = m_pst; m_asu = m_psu;
                    m_pend = 0;
                end
                if (m_k % ROW_TICKS == 0) m_addr = m_at * 6 + m_ast + m_k / ROW_TICKS;
                else if (m_k % ROW_TICKS == 1) m_addr = m_au * 6 + m_asu + m_k / ROW_TICKS;
            end
            if (acc) begin
                m_pend = 1;
                m_pt = sat(t, 9); m_pu = sat(u, 9); m_pst = sat(st, 5); m_psu = sat(su, 5);
            end
        end
        m_bright = bright;
    endtask

    task automatic checkCycle();
        int cnt, row, e_an, e_ca, e_rd, e_fs, pat;
        e_an = 0; e_ca = 'h7F; e_rd = 0; e_fs = 0;
        if (m_run) begin
            cnt  = m_k % ROW_TICKS;
            row  = m_k / ROW_TICKS;
            e_fs = (m_k == 0);
            e_rd = (cnt < 2);
            if (cnt >= BLANK_TICKS) begin
                pat  = (rom_mem[m_at * 6 + m_ast + row] & 7'h70) |
                       (rom_mem[m_au * 6 + m_asu + row] & 7'h0F);
                e_ca = 'h7F ^ pat;
                e_an = ((cnt % 16) <= m_bright) ? (1 << row) : 0;
            end
        end
        checkOutput("frame_start", frame_start, e_fs);
        checkOutput("ANODE", ANODE, e_an);
        checkOutput("CATHODE", CATHODE, e_ca);
        checkOutput("rom_rd", bus.rom_rd, e_rd);
        checkOutput("rom_addr", bus.rom_addr, m_addr);
        checkOutput("upd_ready", bus.upd_ready, !m_pend);
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input int bright, input bit valid,
                                 input int t, input int u, input int st, input int su);
        RST           = rst;
        EN            = en;
        BRIGHT        = 4'(bright);
        bus.upd_valid = valid;
        bus.upd_tens  = 4'(t);
        bus.upd_units = 4'(u);
        bus.upd_scr_t = 3'(st);
        bus.upd_scr_u = 3'(su);
        modelStep(rst, en, bright, valid, t, u, st, su);
        @(negedge CLK);
        checkCycle();
    endtask

    task automatic runCycles(input int n, input bit en, input int upd_pct);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, en, cur_bright, $urandom_range(99) < upd_pct,
                          $urandom_range(15), $urandom_range(15),
                          $urandom_range(7), $urandom_range(7));
        end
    endtask

    task automatic sendUpdate(input int t, input int u, input int st, input int su);
        applyStimulus(0, 1, cur_bright, 1, t, u, st, su);
    endtask

    task automatic runUntil(input int row, input int lo, input int hi, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_run && (m_k / ROW_TICKS) == row &&
                (m_k % ROW_TICKS) >= lo && (m_k % ROW_TICKS) <= hi) begin
                found = 1;
                break;
            end
            applyStimulus(0, 1, cur_bright, 0, 0, 0, 0, 0);
        end
        checkOutput(tag, found, 1);
    endtask

    // Main sequence: directed scenarios followed by a randomized soak.
    initial begin
        bit r, e;
        for (int i = 0; i < 64; i++) rom_mem[i] = 7'($urandom_range(1, 127));

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 15, 0, 0, 0, 0, 0);
        runCycles(4, 0, 0);

        cur_bright = 15;
        runCycles(2 * FRAME, 1, 0);

        runUntil(2, 12, 20, "wait_row2");
        sendUpdate(3, 7, 0, 0);
        runCycles(FRAME + 40, 1, 0);

        cur_bright = 0;
        runCycles(FRAME, 1, 0);
        cur_bright = 7;
        runCycles(FRAME, 1, 0);

        cur_bright = $urandom_range(15);
        sendUpdate(12, 9, 7, 5);
        runCycles(2 * FRAME, 1, 0);

        runUntil(3, BLANK_TICKS + 2, ROW_TICKS - 2, "wait_show_row3");
        runCycles(3, 0, 0);
        runCycles(FRAME + 20, 1, 0);

        runUntil(1, 16, 20, "wait_row1");
        sendUpdate(5, 6, 2, 3);
        runUntil(2, 2, 6, "wait_blank_row2");
        applyStimulus(1, 1, cur_bright, 0, 0, 0, 0, 0);
        runCycles(2 * FRAME, 1, 0);

        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(399) == 0);
            e = ($urandom_range(149) != 0);
            if ($urandom_range(63) == 0) cur_bright = $urandom_range(15);
            applyStimulus(r, e, cur_bright, $urandom_range(19) == 0,
                          $urandom_range(15), $urandom_range(15),
                          $urandom_range(7), $urandom_range(7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
